// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: FSM state encoding, line idle level
//               and frame-length helper used by both transmitter and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] START  = 3'd1;
    localparam logic [STATE_W-1:0] DATA   = 3'd2;
    localparam logic [STATE_W-1:0] PARITY = 3'd3;
    localparam logic [STATE_W-1:0] STOP   = 3'd4;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Total bit periods in one frame, start bit included.
    function automatic int frame_bits(input int data_bits, input int parity_en, input int stop_bits);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_baud_tick
// Description : 14-bit baud down-counter; one-cycle tick at zero, reloads on
//               tick and is held at the reload value while disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_baud_tick #(
    parameter int BAUD_RATE_NUMBER = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [13:0] c_RELOAD = 14'(BAUD_RATE_NUMBER - 1);

    logic [13:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= c_RELOAD;
        end else if (!en || (r_count == 14'd0)) begin
            r_count <= c_RELOAD;
        end else begin
            r_count <= r_count - 14'd1;
        end
    end

    assign tick = en && (r_count == 14'd0);

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter
// Description : UART serializer: start, DATA_BITS data LSB first, optional
//               parity, 1 or 2 stop bits; valid/ready byte input.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
    parameter int BAUD_RATE_NUMBER = 20,
    parameter int DATA_BITS        = 8,
    parameter int PARITY_EN        = 0,
    parameter int PARITY_ODD       = 0,
    parameter int STOP_BITS        = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    import uart_pkg::*;

    localparam logic [3:0] c_LAST_DATA   = 4'(DATA_BITS - 1);
    localparam logic [3:0] c_LAST_STOP   = 4'(STOP_BITS - 1);
    localparam logic       c_PARITY_INIT = (PARITY_ODD != 0);

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_state_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_bit_idx;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_tx_busy;
    logic                 r_tx_ready;

    logic w_tick;
    logic w_baud_en;
    logic w_handshake;
    logic w_last_data;
    logic w_last_stop;
    logic w_shift_out;
    logic w_enter_stop;
    logic w_tx_next;
    logic w_busy_next;
    logic w_ready_next;

    assign w_baud_en    = (r_state != IDLE);
    assign w_handshake  = tx_valid && r_tx_ready;
    assign w_last_data  = (r_bit_idx == c_LAST_DATA);
    assign w_last_stop  = (r_bit_idx == c_LAST_STOP);
    assign w_shift_out  = w_tick && ((r_state == START) || ((r_state == DATA) && !w_last_data));
    assign w_enter_stop = (w_state_next == STOP) && (r_state != STOP);

    uart_tx_baud_tick #(
        .BAUD_RATE_NUMBER(BAUD_RATE_NUMBER)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (w_baud_en),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:   if (w_handshake) w_state_next = START;
            START:  if (w_tick) w_state_next = DATA;
            DATA:   if (w_tick && w_last_data) w_state_next = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY: if (w_tick) w_state_next = STOP;
            STOP:   if (w_tick && w_last_stop) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs; tx only moves on a handshake or a baud tick.
    always_comb begin
        w_tx_next = r_tx;
        case (r_state)
            IDLE:   if (w_handshake) w_tx_next = 1'b0;
            START:  if (w_tick) w_tx_next = r_shift[0];
            DATA: begin
                if (w_tick) begin
                    if (!w_last_data) begin
                        w_tx_next = r_shift[0];
                    end else if (PARITY_EN != 0) begin
                        w_tx_next = r_parity;
                    end else begin
                        w_tx_next = UART_IDLE_LEVEL;
                    end
                end
            end
            PARITY: if (w_tick) w_tx_next = UART_IDLE_LEVEL;
            default: w_tx_next = UART_IDLE_LEVEL;
        endcase
        w_busy_next  = (w_state_next != IDLE);
        w_ready_next = (w_state_next == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx       <= UART_IDLE_LEVEL;
            r_tx_busy  <= 1'b0;
            r_tx_ready <= 1'b1;
            r_shift    <= '0;
            r_bit_idx  <= 4'd0;
            r_parity   <= 1'b0;
        end else begin
            r_tx       <= w_tx_next;
            r_tx_busy  <= w_busy_next;
            r_tx_ready <= w_ready_next;
            if (w_handshake) begin
                r_shift   <= tx_data;
                r_bit_idx <= 4'd0;
                r_parity  <= c_PARITY_INIT;
            end else if (w_shift_out) begin
                // Parity accumulates each data bit as it is placed on the line.
                r_shift  <= r_shift >> 1;
                r_parity <= r_parity ^ r_shift[0];
                if (r_state == DATA) begin
                    r_bit_idx <= r_bit_idx + 4'd1;
                end
            end else if (w_enter_stop) begin
                r_bit_idx <= 4'd0;
            end else if (w_tick && (r_state == STOP)) begin
                r_bit_idx <= r_bit_idx + 4'd1;
            end
        end
    end

    assign tx       = r_tx;
    assign tx_busy  = r_tx_busy;
    assign tx_ready = r_tx_ready;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_transmitter
// Description : Self-checking bench for uart_transmitter over four parameter
//               sets (8N1, 8E1, 8O1, 8N2) against a frame-level bit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

    localparam int N = 20;
    localparam int PEN   [4] = '{0, 1, 1, 0};
    localparam int PODD  [4] = '{0, 0, 1, 0};
    localparam int NSTOP [4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in  [4];
    logic       valid_in [4];
    logic       tx_w     [4];
    logic       rdy_w    [4];
    logic       busy_w   [4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_transmitter #(.BAUD_RATE_NUMBER(N), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_d0 (
        .clk(clk), .rst(rst), .tx_data(data_in[0]), .tx_valid(valid_in[0]),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]));
    uart_transmitter #(.BAUD_RATE_NUMBER(N), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_d1 (
        .clk(clk), .rst(rst), .tx_data(data_in[1]), .tx_valid(valid_in[1]),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]));
    uart_transmitter #(.BAUD_RATE_NUMBER(N), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_d2 (
        .clk(clk), .rst(rst), .tx_data(data_in[2]), .tx_valid(valid_in[2]),
        .tx_ready(rdy_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]));
    uart_transmitter #(.BAUD_RATE_NUMBER(N), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d3 (
        .clk(clk), .rst(rst), .tx_data(data_in[3]), .tx_valid(valid_in[3]),
        .tx_ready(rdy_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        check($sformatf("d%0d %s tx", d, tag), 32'(tx_w[d]), 32'd1);
        check($sformatf("d%0d %s ready", d, tag), 32'(rdy_w[d]), 32'd1);
        check($sformatf("d%0d %s busy", d, tag), 32'(busy_w[d]), 32'd0);
    endtask

    // Present a byte and return just after the posedge on which it was accepted.
    task automatic do_handshake(input int d, input logic [7:0] b);
        bit ok;
        @(negedge clk);
        data_in[d]  = b;
        valid_in[d] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (rdy_w[d]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check($sformatf("d%0d handshake wait", d), 32'(ok), 32'd1);
        @(posedge clk);
    endtask

    // Model: the line must show the frame bit sequence, each level N cycles wide.
    task automatic check_frame(input int d, input logic [7:0] b, input bit keep_valid,
                               input logic [7:0] next_b, input int poke_k,
                               output logic [7:0] dec, output logic par,
                               output int start_cyc, output int low_cnt);
        bit bits[$];
        int f;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (PEN[d] != 0) bits.push_back((^b) ^ (PODD[d] != 0));
        for (int i = 0; i < NSTOP[d]; i++) bits.push_back(1'b1);
        f = bits.size() * N;
        dec = 8'h00;
        par = 1'b0;
        start_cyc = 0;
        low_cnt = 0;
        for (int k = 0; k < f; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start_cyc  = cyc;
                data_in[d] = next_b;
                if (!keep_valid) valid_in[d] = 1'b0;
            end
            if (poke_k >= 0 && k == poke_k) begin
                valid_in[d] = 1'b1;
                data_in[d]  = 8'h00;
            end
            if (poke_k >= 0 && k == poke_k + 1) valid_in[d] = 1'b0;
            if (!rdy_w[d]) low_cnt++;
            check($sformatf("d%0d tx k=%0d", d, k), 32'(tx_w[d]), 32'(bits[k / N]));
            check($sformatf("d%0d busy k=%0d", d, k), 32'(busy_w[d]), 32'd1);
            if (k % N == N / 2) begin
                if (k / N >= 1 && k / N <= 8) dec[k / N - 1] = tx_w[d];
                if (k / N == 9) par = tx_w[d];
            end
        end
        check($sformatf("d%0d ready low cycles", d), 32'(low_cnt), 32'(f));
        @(negedge clk);
        check_idle(d, "frame end");
    endtask

    initial begin : stim
        logic [7:0] dec;
        logic [7:0] b;
        logic       par;
        int         s1, s2, lc;

        for (int i = 0; i < 4; i++) begin
            data_in[i]  = 8'h00;
            valid_in[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) check_idle(i, "reset");
        rst = 1'b0;

        // 8N1 0x55
        do_handshake(0, 8'h55);
        check_frame(0, 8'h55, 1'b0, 8'h55, -1, dec, par, s1, lc);
        check("0x55 decode", 32'(dec), 32'h55);
        check("0x55 ready low", 32'(lc), 32'd200);

        // back-to-back with tx_valid held
        do_handshake(0, 8'hA5);
        check_frame(0, 8'hA5, 1'b1, 8'h3C, -1, dec, par, s1, lc);
        check("b2b first decode", 32'(dec), 32'hA5);
        @(posedge clk);
        check_frame(0, 8'h3C, 1'b0, 8'h3C, -1, dec, par, s2, lc);
        check("b2b second decode", 32'(dec), 32'h3C);
        check("b2b start spacing", 32'(s2 - s1), 32'd201);

        // parity even / odd
        do_handshake(1, 8'h07);
        check_frame(1, 8'h07, 1'b0, 8'h07, -1, dec, par, s1, lc);
        check("even parity bit", 32'(par), 32'd1);
        check("even frame len", 32'(lc), 32'd220);
        do_handshake(2, 8'h07);
        check_frame(2, 8'h07, 1'b0, 8'h07, -1, dec, par, s1, lc);
        check("odd parity bit", 32'(par), 32'd0);
        check("odd frame len", 32'(lc), 32'd220);

        // two stop bits
        do_handshake(3, 8'hFF);
        check_frame(3, 8'hFF, 1'b0, 8'hFF, -1, dec, par, s1, lc);
        check("2stop decode", 32'(dec), 32'hFF);
        check("2stop frame len", 32'(lc), 32'd220);

        // tx_valid pulse and data change mid-frame are ignored
        do_handshake(0, 8'h96);
        check_frame(0, 8'h96, 1'b0, 8'h96, 50, dec, par, s1, lc);
        check("midframe decode", 32'(dec), 32'h96);
        for (int k = 0; k < 2 * N; k++) begin
            @(negedge clk);
            check_idle(0, "no second frame");
        end

        // reset at clk 75 of a 0x00 frame
        do_handshake(0, 8'h00);
        for (int k = 0; k < 75; k++) begin
            @(negedge clk);
            if (k == 0) valid_in[0] = 1'b0;
            check($sformatf("pre-reset tx k=%0d", k), 32'(tx_w[0]), 32'd0);
        end
        #2 rst = 1'b1;
        #1 check_idle(0, "async reset");
        @(posedge clk);
        #1 check_idle(0, "held reset");
        @(negedge clk);
        rst = 1'b0;
        do_handshake(0, 8'h81);
        check_frame(0, 8'h81, 1'b0, 8'h81, -1, dec, par, s1, lc);
        check("post-reset decode", 32'(dec), 32'h81);

        // random bytes on every configuration
        for (int d = 0; d < 4; d++) begin
            for (int r = 0; r < 3; r++) begin
                b = 8'($urandom);
                do_handshake(d, b);
                check_frame(d, b, 1'b0, b, -1, dec, par, s1, lc);
                check($sformatf("d%0d random decode", d), 32'(dec), 32'(b));
                if (PEN[d] != 0) check($sformatf("d%0d random parity", d), 32'(par), 32'((^b) ^ (PODD[d] != 0)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serializes parallel bytes onto a single UART line: start bit, DATA_BITS data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- Forms the transmit end of the UART link, paired with the existing receiver.
- Uses the same baud convention as the receiver: one bit period equals BAUD_RATE_NUMBER clk cycles.
- Upstream logic hands in bytes over a valid/ready handshake.

Parameters:
- BAUD_RATE_NUMBER, 20: clk cycles per bit period. Legal range is 2..16383; the baud counter is 14 bits.
- DATA_BITS, 8: data bits per frame. Legal range is 5..9.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
- tx_valid  input  1  upstream has a byte.
- tx_ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line; idles high.
- tx_busy  output  1  a frame is in progress.

Behaviour:
- Reset (asynchronous, active-high): tx=1, tx_ready=1, tx_busy=0, state=IDLE, baud counter=BAUD_RATE_NUMBER-1, shift register=0. All outputs are registered.
- Reset mid-frame aborts the frame immediately. tx returns to 1 asynchronously. No partial-frame recovery after reset is released.
- Handshake: a transfer occurs on a rising edge where tx_valid=1 and tx_ready=1.
- tx_ready=1 exactly when state==IDLE.
- tx_valid while busy is ignored; no queuing.
- tx_data is latched only at the handshake edge; changes during the frame have no effect.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on handshake. At that edge: tx<=0, tx_busy<=1, counter<=BAUD_RATE_NUMBER-1, shift<=tx_data, bit index<=0, parity accumulator<=PARITY_ODD.
  - Baud counter runs only outside IDLE. It decrements each clk; when it is 0 at an edge it reloads to BAUD_RATE_NUMBER-1 and the bit advances. Every bit is therefore exactly BAUD_RATE_NUMBER cycles wide.
  - START -> DATA: tx<=shift[0], shift right, parity ^= bit.
  - DATA: after DATA_BITS bits go to PARITY if PARITY_EN=1, otherwise to STOP. Entering PARITY drives tx<=accumulator; entering STOP drives tx<=1.
  - PARITY -> STOP: tx<=1.
  - STOP: stays for STOP_BITS bit periods, then goes to IDLE. At that edge tx_busy<=0; tx stays 1.
- Latency:
  - tx falls at the first edge after the handshake.
  - Frame length F = BAUD_RATE_NUMBER*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles.
- Back-to-back: tx_ready is high for at least one cycle between frames. With tx_valid held, the next start bit begins F+1 cycles after the previous one.
- Parity: even parity gives an even count of 1s over data+parity; odd parity gives an odd count.
- No glitches: tx changes only on baud boundaries or reset.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), shared with the receiver;
  - UART_IDLE_LEVEL=1'b1;
  - function frame_bits(data_bits, parity_en, stop_bits).
- Sub-module uart_tx_baud_tick:
  - 14-bit down-counter with enable and synchronous reload;
  - outputs a one-cycle tick when the counter reaches 0;
  - held at BAUD_RATE_NUMBER-1 while disabled.

Test Plan:
- Defaults (N=20, 8N1), send 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1 with each level exactly 20 clks. tx_ready is low for 200 clks and rises at clk 200 after the handshake.
- tx_valid held high with 0xA5 then 0x3C -> second start bit falls exactly 201 clks after the first. Decoded bytes are 0xA5 then 0x3C, LSB first.
- PARITY_EN=1, even, send 0x07 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. Frame is 220 clks.
- STOP_BITS=2, send 0xFF -> tx high for 40 clks after the last data bit before tx_ready rises.
- During a frame, pulse tx_valid and change tx_data to 0x00 -> frame still carries the original byte; no second frame is sent.
- Assert rst at clk 75 of a 0x00 frame -> tx=1 and tx_ready=1 immediately. After release, 0x81 sends cleanly with a correct start bit 1 clk after the handshake.
